// File: rtl/idx_gather_seq_if.sv
// ---------------------------------------------------------------------------
// idx_gather_seq_if
// Gather request channel from the index sequencer to the gather datapath.
//
// Handshake: a request transfers on a rising clock edge where req_valid and
// req_ready are both high. Once req_valid is raised, req_addr and req_seq
// stay stable and req_valid stays high until that transfer happens.
// req_ready may be driven freely and need not wait for req_valid.
//
// Signals
//   req_valid  master -> slave  request present
//   req_ready  slave  -> master request accepted when valid & ready
//   req_addr   master -> slave  gather byte address (OUT_AW bits)
//   req_seq    master -> slave  entry ordinal, modulo 2^ADDR_WIDTH
// ---------------------------------------------------------------------------
interface idx_gather_seq_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int OUT_AW     = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [OUT_AW-1:0]     req_addr;
  logic [ADDR_WIDTH-1:0] req_seq;

  modport master (
    output req_valid,
    output req_addr,
    output req_seq,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_seq,
    output req_ready
  );
endinterface

// File: rtl/idx_gather_seq.sv
// ---------------------------------------------------------------------------
// idx_gather_seq
// Read side of the index RAM. On start, walks cfg_count consecutive entries
// from cfg_base through the RAM's combinational read port, turns each index
// into a gather byte address (data_base + (idx << ELEM_SHIFT)) and issues it
// on the req channel at up to one request per cycle.
//
// Optional feature macro: IDX_BOUNDS_CHECK_EN
//   When defined, adds cfg_idx_limit (latched at start) and err_oob. Entries
//   with idx >= limit are consumed without issuing a request and set the
//   sticky err_oob flag (cleared by the next accepted start or by rst).
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   start            1-cycle pulse, honoured only in IDLE
//   cfg_base         first index RAM address
//   cfg_count        number of entries, 0..2^ADDR_WIDTH
//   cfg_data_base    gather base byte address
//   cfg_idx_limit    (IDX_BOUNDS_CHECK_EN) exclusive upper bound on idx
//   err_oob          (IDX_BOUNDS_CHECK_EN) sticky out-of-bounds flag
//   idx_raddr        RAM read address (registered pointer)
//   idx_rdata        RAM read data, valid in the same cycle as idx_raddr
//   req              gather request channel (master side)
//   busy             high in RUN and DONE
//   done             1-cycle pulse after the last handshake
//   dbg_state_o      current FSM state for observation
// ---------------------------------------------------------------------------
module idx_gather_seq #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int OUT_AW     = 32,
  parameter int ELEM_SHIFT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH:0]   cfg_count,
  input  logic [OUT_AW-1:0]     cfg_data_base,
`ifdef IDX_BOUNDS_CHECK_EN
  input  logic [DATA_WIDTH-1:0] cfg_idx_limit,
  output logic                  err_oob,
`endif
  output logic [ADDR_WIDTH-1:0] idx_raddr,
  input  logic [DATA_WIDTH-1:0] idx_rdata,
  idx_gather_seq_if.master      req,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Architectural state
  logic [1:0]            state_q,     state_d;
  logic [ADDR_WIDTH-1:0] ptr_q,       ptr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic [OUT_AW-1:0]     base_q,      base_d;
  logic [ADDR_WIDTH-1:0] issued_q,    issued_d;
  logic                  req_valid_q, req_valid_d;
  logic [OUT_AW-1:0]     req_addr_q,  req_addr_d;
  logic [ADDR_WIDTH-1:0] req_seq_q,   req_seq_d;
`ifdef IDX_BOUNDS_CHECK_EN
  logic [DATA_WIDTH-1:0] limit_q,     limit_d;
  logic                  err_q,       err_d;
`endif

  // Datapath helpers
  logic              slot_free;
  logic              load;
  logic              oob;
  logic [OUT_AW-1:0] idx_ext;
  logic [OUT_AW-1:0] gather_addr;

  // The output register can take a new entry when it is empty or its
  // current request is being accepted this cycle.
  assign slot_free = !req_valid_q || req.req_ready;
  assign load      = (state_q == S_RUN) && (remaining_q != '0) && slot_free;

  // Zero-extend before shifting so high index bits are not lost; the sum
  // wraps modulo 2^OUT_AW.
  assign idx_ext     = OUT_AW'(idx_rdata);
  assign gather_addr = base_q + (idx_ext << ELEM_SHIFT);

`ifdef IDX_BOUNDS_CHECK_EN
  assign oob = (idx_rdata >= limit_q);
`else
  assign oob = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    base_d      = base_q;
    issued_d    = issued_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_seq_d   = req_seq_q;
`ifdef IDX_BOUNDS_CHECK_EN
    limit_d     = limit_q;
    err_d       = err_q;
`endif

    // Accepted request with nothing to replace it empties the register.
    if (req_valid_q && req.req_ready) begin
      req_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RUN;
          ptr_d       = cfg_base;
          remaining_d = cfg_count;
          base_d      = cfg_data_base;
          issued_d    = '0;
`ifdef IDX_BOUNDS_CHECK_EN
          limit_d     = cfg_idx_limit;
          err_d       = 1'b0;
`endif
        end
      end

      S_RUN: begin
        if (load) begin
          // Entry is consumed whether or not it produces a request.
          ptr_d       = ptr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (!oob) begin
            req_valid_d = 1'b1;
            req_addr_d  = gather_addr;
            req_seq_d   = issued_q;
            issued_d    = issued_q + 1'b1;
          end else begin
`ifdef IDX_BOUNDS_CHECK_EN
            err_d       = 1'b1;
`endif
          end
        end else if ((remaining_q == '0) && slot_free) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      base_q      <= '0;
      issued_q    <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_seq_q   <= '0;
`ifdef IDX_BOUNDS_CHECK_EN
      limit_q     <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      base_q      <= base_d;
      issued_q    <= issued_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_seq_q   <= req_seq_d;
`ifdef IDX_BOUNDS_CHECK_EN
      limit_q     <= limit_d;
      err_q       <= err_d;
`endif
    end
  end

  assign idx_raddr     = ptr_q;
  assign req.req_valid = req_valid_q;
  assign req.req_addr  = req_addr_q;
  assign req.req_seq   = req_seq_q;
  assign busy          = (state_q == S_RUN) || (state_q == S_DONE);
  assign done          = (state_q == S_DONE);
  assign dbg_state_o   = state_q;
`ifdef IDX_BOUNDS_CHECK_EN
  assign err_oob       = err_q;
`endif

endmodule

// File: tb/tb_idx_gather_seq.sv
// ---------------------------------------------------------------------------
// tb_idx_gather_seq
// Directed bench for idx_gather_seq. Inputs change and outputs are sampled on
// the falling clock edge. Cycle n after a start means the n-th falling edge
// after the rising edge that sampled start (n=1 is cycle T+1).
// ---------------------------------------------------------------------------
module tb_idx_gather_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  cfg_base;
  logic [10:0] cfg_count;
  logic [31:0] cfg_data_base;
  logic [9:0]  idx_raddr;
  logic [15:0] idx_rdata;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;
`ifdef IDX_BOUNDS_CHECK_EN
  logic [15:0] cfg_idx_limit;
  logic        err_oob;
`endif

  logic [15:0] ram [1024];
  int total = 0;
  int bad   = 0;

  idx_gather_seq_if #(.ADDR_WIDTH(10), .OUT_AW(32)) req_if ();

  assign idx_rdata = ram[idx_raddr];

  idx_gather_seq #(
    .ADDR_WIDTH(10), .DATA_WIDTH(16), .OUT_AW(32), .ELEM_SHIFT(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_base      (cfg_base),
    .cfg_count     (cfg_count),
    .cfg_data_base (cfg_data_base),
`ifdef IDX_BOUNDS_CHECK_EN
    .cfg_idx_limit (cfg_idx_limit),
    .err_oob       (err_oob),
`endif
    .idx_raddr     (idx_raddr),
    .idx_rdata     (idx_rdata),
    .req           (req_if),
    .busy          (busy),
    .done          (done),
    .dbg_state_o   (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  // Drive a start pulse at the current falling edge; returns at cycle T+1.
  task automatic pulse_start(input logic [9:0] b, input logic [10:0] c,
                             input logic [31:0] db);
    cfg_base      = b;
    cfg_count     = c;
    cfg_data_base = db;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; req_if.req_ready = 1'b0;
    cfg_base = '0; cfg_count = '0; cfg_data_base = '0;
`ifdef IDX_BOUNDS_CHECK_EN
    cfg_idx_limit = 16'hFFFF;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (req_if.req_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", req_if.req_valid); end
    total++; if (req_if.req_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", req_if.req_addr); end
    total++; if (req_if.req_seq !== 10'd0) begin bad++; $display("FAIL reset_seq got=%0d exp=0", req_if.req_seq); end
    total++; if (idx_raddr !== 10'd0) begin bad++; $display("FAIL reset_raddr got=%0d exp=0", idx_raddr); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_busy_done got=%0b%0b exp=00", busy, done); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
  endtask

  // RAM {5,0,3}: addresses 0x1014, 0x1000, 0x100C from T+2, done at T+5.
  // A start during RUN with scrambled cfg must be ignored.
  task automatic test_basic();
    logic [31:0] exp_a [3];
    exp_a = '{32'h1014, 32'h1000, 32'h100C};
    ram[0] = 16'd5; ram[1] = 16'd0; ram[2] = 16'd3;
    req_if.req_ready = 1'b1;
    pulse_start(10'd0, 11'd3, 32'h1000);
    cfg_base = 10'h155; cfg_count = 11'd7; cfg_data_base = 32'hDEAD0000;
    total++; if (busy !== 1'b1 || req_if.req_valid !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL basic_t1 busy/valid/done got=%0b%0b%0b exp=100", busy, req_if.req_valid, done); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = (i == 0);
      total++; if (req_if.req_valid !== 1'b1 || req_if.req_addr !== exp_a[i] || req_if.req_seq !== 10'(i)) begin
        bad++; $display("FAIL basic_req%0d got v=%0b a=%h s=%0d exp v=1 a=%h s=%0d",
                        i, req_if.req_valid, req_if.req_addr, req_if.req_seq, exp_a[i], i); end
    end
    start = 1'b0;
    @(negedge clk);
    total++; if (done !== 1'b1 || busy !== 1'b1 || req_if.req_valid !== 1'b0) begin
      bad++; $display("FAIL basic_done_t5 done/busy/valid got=%0b%0b%0b exp=110", done, busy, req_if.req_valid); end
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      bad++; $display("FAIL basic_idle_t6 done/busy/state got=%0b%0b%0d exp=0 0 0", done, busy, dbg_state); end
  endtask

  // count=0: no request, done at T+2, busy over T+1..T+2.
  task automatic test_zero_count();
    req_if.req_ready = 1'b1;
    pulse_start(10'd5, 11'd0, 32'h1000);
    total++; if (busy !== 1'b1 || done !== 1'b0 || req_if.req_valid !== 1'b0) begin
      bad++; $display("FAIL zero_t1 busy/done/valid got=%0b%0b%0b exp=100", busy, done, req_if.req_valid); end
    @(negedge clk);
    total++; if (busy !== 1'b1 || done !== 1'b1 || req_if.req_valid !== 1'b0) begin
      bad++; $display("FAIL zero_t2 busy/done/valid got=%0b%0b%0b exp=110", busy, done, req_if.req_valid); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0 || req_if.req_valid !== 1'b0) begin
      bad++; $display("FAIL zero_t3 busy/done/valid got=%0b%0b%0b exp=000", busy, done, req_if.req_valid); end
  endtask

  // count=4 with ready held low for 3 cycles while request seq 1 is shown.
  task automatic test_backpressure();
    logic [31:0] exp_q [$];
    int stalls = 0;
    int hs = 0;
    bit seen_done = 0;
    ram[10] = 16'd1; ram[11] = 16'd2; ram[12] = 16'd3; ram[13] = 16'hFFFE;
    exp_q.push_back(32'h2004); exp_q.push_back(32'h2008);
    exp_q.push_back(32'h200C); exp_q.push_back(32'h41FF8);
    req_if.req_ready = 1'b1;
    pulse_start(10'd10, 11'd4, 32'h2000);
    for (int cyc = 0; cyc < 40 && !seen_done; cyc++) begin
      if (req_if.req_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++; bad++; $display("FAIL bp_extra got a=%h exp=no request", req_if.req_addr);
        end else begin
          total++; if (req_if.req_addr !== exp_q[0] || req_if.req_seq !== 10'(hs)) begin
            bad++; $display("FAIL bp_req got a=%h s=%0d exp a=%h s=%0d",
                            req_if.req_addr, req_if.req_seq, exp_q[0], hs); end
        end
        if (req_if.req_seq == 10'd1 && stalls < 3) begin
          req_if.req_ready = 1'b0; stalls++;
        end else begin
          req_if.req_ready = 1'b1;
        end
        if (req_if.req_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front()); hs++;
        end
      end else begin
        req_if.req_ready = 1'b1;
      end
      if (done === 1'b1) seen_done = 1;
      else @(negedge clk);
    end
    req_if.req_ready = 1'b1;
    total++; if (hs != 4 || exp_q.size() != 0) begin
      bad++; $display("FAIL bp_count got handshakes=%0d left=%0d exp 4 0", hs, exp_q.size()); end
    total++; if (stalls != 3) begin bad++; $display("FAIL bp_stalls got=%0d exp=3", stalls); end
    total++; if (!seen_done) begin bad++; $display("FAIL bp_done got=no done exp=done pulse"); end
    @(negedge clk);
  endtask

  // base=1022, count=4: read pointer wraps; address sum wraps at 32 bits.
  task automatic test_wrap();
    logic [9:0]  exp_ra [4];
    logic [31:0] exp_a  [4];
    exp_ra = '{10'd1022, 10'd1023, 10'd0, 10'd1};
    exp_a  = '{32'h34, 32'h78, 32'hBC, 32'h100};
    ram[1022] = 16'h11; ram[1023] = 16'h22; ram[0] = 16'h33; ram[1] = 16'h44;
    req_if.req_ready = 1'b1;
    pulse_start(10'd1022, 11'd4, 32'hFFFF_FFF0);
    for (int i = 0; i < 4; i++) begin
      total++; if (idx_raddr !== exp_ra[i]) begin
        bad++; $display("FAIL wrap_raddr%0d got=%0d exp=%0d", i, idx_raddr, exp_ra[i]); end
      @(negedge clk);
      total++; if (req_if.req_valid !== 1'b1 || req_if.req_addr !== exp_a[i] || req_if.req_seq !== 10'(i)) begin
        bad++; $display("FAIL wrap_req%0d got v=%0b a=%h s=%0d exp v=1 a=%h s=%0d",
                        i, req_if.req_valid, req_if.req_addr, req_if.req_seq, exp_a[i], i); end
    end
    @(negedge clk);
    total++; if (done !== 1'b1 || idx_raddr !== 10'd2) begin
      bad++; $display("FAIL wrap_end got done=%0b raddr=%0d exp done=1 raddr=2", done, idx_raddr); end
    @(negedge clk);
  endtask

  // rst while a request is pending; then a clean run.
  task automatic test_reset_mid_run();
    ram[0] = 16'd5; ram[1] = 16'd0; ram[2] = 16'd3; ram[3] = 16'd9;
    req_if.req_ready = 1'b0;
    pulse_start(10'd0, 11'd4, 32'h1000);
    @(negedge clk);
    total++; if (req_if.req_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre_valid got=%0b exp=1", req_if.req_valid); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (req_if.req_valid !== 1'b0 || req_if.req_addr !== 32'h0 || req_if.req_seq !== 10'd0 || idx_raddr !== 10'd0) begin
      bad++; $display("FAIL rstmid_outputs got v=%0b a=%h s=%0d r=%0d exp all 0",
                      req_if.req_valid, req_if.req_addr, req_if.req_seq, idx_raddr); end
    total++; if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== 2'd0) begin
      bad++; $display("FAIL rstmid_state got busy=%0b done=%0b st=%0d exp 0 0 0", busy, done, dbg_state); end
    rst = 1'b0;
    req_if.req_ready = 1'b1;
    pulse_start(10'd0, 11'd2, 32'h1000);
    @(negedge clk);
    total++; if (req_if.req_valid !== 1'b1 || req_if.req_addr !== 32'h1014 || req_if.req_seq !== 10'd0) begin
      bad++; $display("FAIL rstmid_req0 got v=%0b a=%h s=%0d exp 1 1014 0", req_if.req_valid, req_if.req_addr, req_if.req_seq); end
    @(negedge clk);
    total++; if (req_if.req_valid !== 1'b1 || req_if.req_addr !== 32'h1000 || req_if.req_seq !== 10'd1) begin
      bad++; $display("FAIL rstmid_req1 got v=%0b a=%h s=%0d exp 1 1000 1", req_if.req_valid, req_if.req_addr, req_if.req_seq); end
    @(negedge clk);
    total++; if (done !== 1'b1 || req_if.req_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid_done got done=%0b v=%0b exp 1 0", done, req_if.req_valid); end
    @(negedge clk);
  endtask

`ifdef IDX_BOUNDS_CHECK_EN
  // limit=4, RAM {1,7,2}: requests for idx 1 and 2 only, err_oob after 7.
  task automatic test_bounds();
    ram[0] = 16'd1; ram[1] = 16'd7; ram[2] = 16'd2;
    cfg_idx_limit = 16'd4;
    req_if.req_ready = 1'b1;
    pulse_start(10'd0, 11'd3, 32'h0);
    cfg_idx_limit = 16'hFFFF;
    total++; if (err_oob !== 1'b0) begin bad++; $display("FAIL oob_t1 err got=%0b exp=0", err_oob); end
    @(negedge clk);
    total++; if (req_if.req_valid !== 1'b1 || req_if.req_addr !== 32'h4 || req_if.req_seq !== 10'd0 || err_oob !== 1'b0) begin
      bad++; $display("FAIL oob_t2 got v=%0b a=%h s=%0d e=%0b exp 1 4 0 0", req_if.req_valid, req_if.req_addr, req_if.req_seq, err_oob); end
    @(negedge clk);
    total++; if (req_if.req_valid !== 1'b0 || err_oob !== 1'b1) begin
      bad++; $display("FAIL oob_t3 got v=%0b e=%0b exp 0 1", req_if.req_valid, err_oob); end
    @(negedge clk);
    total++; if (req_if.req_valid !== 1'b1 || req_if.req_addr !== 32'h8 || req_if.req_seq !== 10'd1 || err_oob !== 1'b1) begin
      bad++; $display("FAIL oob_t4 got v=%0b a=%h s=%0d e=%0b exp 1 8 1 1", req_if.req_valid, req_if.req_addr, req_if.req_seq, err_oob); end
    @(negedge clk);
    total++; if (done !== 1'b1 || err_oob !== 1'b1) begin
      bad++; $display("FAIL oob_done got done=%0b e=%0b exp 1 1", done, err_oob); end
    @(negedge clk);
    pulse_start(10'd0, 11'd0, 32'h0);
    total++; if (err_oob !== 1'b0) begin bad++; $display("FAIL oob_clear got=%0b exp=0", err_oob); end
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_backpressure();
    test_wrap();
    test_reset_mid_run();
`ifdef IDX_BOUNDS_CHECK_EN
    test_bounds();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
